// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding,
// default abort limit and timer width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INST = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam int         DEFAULT_TIMEOUT = 255;
  localparam int         TMR_W           = 8;
  localparam logic [3:0] BE_WORD         = 4'hF;

endpackage

// File: rtl/arb_timer.sv
// Counts cycles of an outstanding memory request; expired flags the
// TIMEOUT-th request cycle so the arbiter can abort on that edge.
module arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  // count holds the number of request cycles already completed
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM
// stage; data always wins, one transaction outstanding, abort on timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  input  logic        flush_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_be_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        pc_stall_o,
  output logic        if_stall_o,
  output logic        mem_stall_o,
  output logic        err_o
);

  arb_state_e state;
  logic       kill;
  logic       hold;
  logic       grant;
  logic       timer_exp;

  // The cycle after any completion (strobe or killed fetch) is a forced idle
  // so the requester can retire its request before the next arbitration.
  assign hold  = inst_valid_o | data_ack_o | err_o | kill;
  assign grant = (state == ST_IDLE) && !hold && (data_req_i || inst_ce_i);

  assign pc_stall_o  = inst_ce_i & ~inst_valid_o;
  assign if_stall_o  = inst_ce_i & ~inst_valid_o;
  assign mem_stall_o = data_req_i & ~data_ack_o;

  arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant),
    .en     (mem_req_o),
    .expired(timer_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      kill         <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= '0;
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      data_rdata_o <= '0;
      data_ack_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      data_ack_o   <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        ST_IDLE: begin
          kill <= 1'b0;
          if (grant) begin
            mem_req_o <= 1'b1;
            if (data_req_i) begin
              state       <= ST_DATA;
              mem_we_o    <= data_we_i;
              mem_addr_o  <= data_addr_i;
              mem_wdata_o <= data_wdata_i;
              mem_be_o    <= data_be_i;
            end else begin
              state       <= ST_INST;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= inst_addr_i;
              mem_wdata_o <= '0;
              mem_be_o    <= BE_WORD;
            end
          end
        end
        ST_INST: begin
          // a flush seen anywhere in the fetch, ack cycle included, discards it
          kill <= kill | flush_i;
          if (mem_ack_i) begin
            state     <= ST_IDLE;
            mem_req_o <= 1'b0;
            if (!(kill || flush_i)) begin
              inst_o       <= mem_rdata_i;
              inst_valid_o <= 1'b1;
            end
          end else if (timer_exp) begin
            state     <= ST_IDLE;
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
          end
        end
        ST_DATA: begin
          if (mem_ack_i) begin
            state      <= ST_IDLE;
            mem_req_o  <= 1'b0;
            data_ack_o <= 1'b1;
            if (!mem_we_o) begin
              data_rdata_o <= mem_rdata_i;
            end
          end else if (timer_exp) begin
            state     <= ST_IDLE;
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and
// request-ordering model; includes the directed fetch/collision/flush/write/timeout/reset cases.
module tb_mem_arbiter;

  localparam int TO     = 4;
  localparam int NO_ACK = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        flush_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_rdata_o;
  logic        data_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        pc_stall_o;
  logic        if_stall_o;
  logic        mem_stall_o;
  logic        err_o;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .flush_i(flush_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_rdata_o(data_rdata_o), .data_ack_o(data_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_o), .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
  } bus_t;

  typedef struct {
    int          kind;   // 0 fetch word, 1 data ack, 2 error strobe
    logic [31:0] val;
  } resp_t;

  bus_t        bus_q[$];
  resp_t       exp_q[$];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] last_rd = 32'h0;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          abort_ok = 1'b0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] phys_rd(logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_mem_req"},   32'(mem_req_o),    32'd0);
    chk({tag, "_mem_we"},    32'(mem_we_o),     32'd0);
    chk({tag, "_mem_addr"},  mem_addr_o,        32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o,       32'd0);
    chk({tag, "_mem_be"},    32'(mem_be_o),     32'd0);
    chk({tag, "_inst"},      inst_o,            32'd0);
    chk({tag, "_inst_vld"},  32'(inst_valid_o), 32'd0);
    chk({tag, "_rdata"},     data_rdata_o,      32'd0);
    chk({tag, "_data_ack"},  32'(data_ack_o),   32'd0);
    chk({tag, "_err"},       32'(err_o),        32'd0);
  endtask

  // Memory-side model: acks on request cycle `lat`, never if lat exceeds TO.
  initial begin : responder
    bus_t cur;
    int   cnt;
    bit   active, acked;
    active      = 1'b0;
    acked       = 1'b0;
    cnt         = 0;
    cur         = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, be: 4'h0, lat: 1};
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        if (!active) begin
          active = 1'b1;
          acked  = 1'b0;
          cnt    = 1;
          if (bus_q.size() == 0) begin
            chk("bus_unexpected_req", mem_addr_o, 32'hFFFF_FFFF);
            cur = '{addr: mem_addr_o, we: mem_we_o, wdata: mem_wdata_o, be: mem_be_o, lat: 1};
          end else begin
            cur = bus_q.pop_front();
            chk("bus_addr", mem_addr_o, cur.addr);
            chk("bus_we", 32'(mem_we_o), 32'(cur.we));
            chk("bus_be", 32'(mem_be_o), 32'(cur.be));
            if (cur.we) chk("bus_wdata", mem_wdata_o, cur.wdata);
          end
        end else begin
          cnt++;
          chk("bus_hold_addr", mem_addr_o, cur.addr);
          chk("bus_hold_we", 32'(mem_we_o), 32'(cur.we));
          chk("bus_hold_be", 32'(mem_be_o), 32'(cur.be));
        end
        if (cnt == cur.lat) begin
          mem_ack_i = 1'b1;
          acked     = 1'b1;
          if (mem_we_o) begin
            phys_mem[mem_addr_o] = merge(phys_rd(mem_addr_o), mem_wdata_o, mem_be_o);
            mem_rdata_i = $urandom;
          end else begin
            mem_rdata_i = phys_rd(mem_addr_o);
          end
        end else begin
          mem_rdata_i = $urandom;
        end
      end else begin
        if (active && !acked && !abort_ok) chk("timeout_req_cycles", 32'(cnt), 32'(TO));
        active      = 1'b0;
        mem_ack_i   = ($urandom_range(0, 7) == 0);   // stray acks while idle
        mem_rdata_i = $urandom;
      end
    end
  end

  // Scoreboard: pops one expectation per strobe, checks stall equations.
  initial begin : monitor
    resp_t       e;
    int          k;
    logic [31:0] v;
    forever begin
      @(negedge clk);
      if (rst) continue;
      chk("pc_stall", 32'(pc_stall_o), 32'(inst_ce_i & ~inst_valid_o));
      chk("if_stall", 32'(if_stall_o), 32'(inst_ce_i & ~inst_valid_o));
      chk("mem_stall", 32'(mem_stall_o), 32'(data_req_i & ~data_ack_o));
      if (inst_valid_o || data_ack_o || err_o) begin
        chk("one_strobe", 32'(inst_valid_o) + 32'(data_ack_o) + 32'(err_o), 32'd1);
        k = inst_valid_o ? 0 : (data_ack_o ? 1 : 2);
        v = inst_valid_o ? inst_o : (data_ack_o ? data_rdata_o : 32'h0);
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", 32'(k), 32'hFF);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(k), 32'(e.kind));
          chk("strobe_value", v, e.val);
        end
      end
    end
  end

  task automatic issue_inst(logic [31:0] a, int lat, bit killed);
    bus_q.push_back('{addr: a, we: 1'b0, wdata: 32'h0, be: 4'hF, lat: lat});
    if (lat > TO)    exp_q.push_back('{kind: 2, val: 32'h0});
    else if (!killed) exp_q.push_back('{kind: 0, val: ref_rd(a)});
    inst_addr_i = a;
    inst_ce_i   = 1'b1;
  endtask

  task automatic issue_data(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be, int lat);
    bus_q.push_back('{addr: a, we: we, wdata: wd, be: be, lat: lat});
    if (lat > TO) begin
      exp_q.push_back('{kind: 2, val: 32'h0});
    end else begin
      if (we) ref_mem[a] = merge(ref_rd(a), wd, be);
      else    last_rd    = ref_rd(a);
      exp_q.push_back('{kind: 1, val: last_rd});
    end
    data_we_i    = we;
    data_addr_i  = a;
    data_wdata_i = wd;
    data_be_i    = be;
    data_req_i   = 1'b1;
  endtask

  // mode: 0 fetch, 1 data, 2 data+fetch together, 3 fetch then data, 4 flushed fetch then new fetch
  task automatic run_round(int mode, logic [31:0] ia, int il, logic dwe, logic [31:0] da,
                           logic [31:0] dwd, logic [3:0] dbe, int dl, logic [31:0] fa, int fl);
    int order[$];
    int k;
    int cyc;
    bit flushed;
    cyc     = 0;
    flushed = 1'b0;
    @(posedge clk); #1;
    case (mode)
      0: begin issue_inst(ia, il, 1'b0); order.push_back(0); end
      1: begin issue_data(dwe, da, dwd, dbe, dl); order.push_back(1); end
      2: begin
        issue_data(dwe, da, dwd, dbe, dl);
        issue_inst(ia, il, 1'b0);
        order.push_back(1);
        order.push_back(0);
      end
      3: begin issue_inst(ia, il, 1'b0); order.push_back(0); end
      default: begin issue_inst(ia, il, 1'b1); order.push_back(0); end
    endcase
    while (order.size() > 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      flush_i = 1'b0;
      if (inst_valid_o || data_ack_o || err_o) begin
        k = order.pop_front();
        if (k == 0) inst_ce_i = 1'b0;
        else        data_req_i = 1'b0;
      end
      if (mode == 3 && cyc == 1) begin
        issue_data(dwe, da, dwd, dbe, dl);
        order.push_back(1);
      end
      if (mode == 4 && !flushed && mem_req_o) begin
        flush_i = 1'b1;
        issue_inst(fa, fl, 1'b0);
        flushed = 1'b1;
      end
    end
    chk("round_done", 32'(order.size()), 32'd0);
    inst_ce_i  = 1'b0;
    data_req_i = 1'b0;
    flush_i    = 1'b0;
    repeat (1 + $urandom_range(0, 2)) @(posedge clk);
    #1;
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_drained", 32'(bus_q.size()), 32'd0);
  endtask

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 9);
    return (r == 0) ? NO_ACK : 1 + (r % 6);
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int cyc;
    rst          = 1'b1;
    inst_ce_i    = 1'b0;
    inst_addr_i  = 32'h0;
    flush_i      = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    data_be_i    = 4'h0;
    ref_mem[32'h100]  = 32'h0050_0093;
    phys_mem[32'h100] = 32'h0050_0093;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // single fetch, ack two cycles after the request rises
    run_round(0, 32'h100, 3, 1'b0, 32'h0, 32'h0, 4'hF, 1, 32'h0, 1);
    // collision: data read first, then the fetch
    run_round(2, 32'h104, 2, 1'b0, 32'h200, 32'h0, 4'hF, 2, 32'h0, 1);
    // flushed fetch, redirected to 0x300
    run_round(4, 32'h108, 2, 1'b0, 32'h0, 32'h0, 4'hF, 1, 32'h300, 2);
    // partial write leaves data_rdata_o alone, read back the merge
    run_round(1, 32'h0, 1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 2, 32'h0, 1);
    run_round(1, 32'h0, 1, 1'b0, 32'h200, 32'h0, 4'hF, 1, 32'h0, 1);
    // timeout with no ack, ack on exactly the limit, data timeout
    run_round(0, 32'h110, NO_ACK, 1'b0, 32'h0, 32'h0, 4'hF, 1, 32'h0, 1);
    run_round(0, 32'h114, TO, 1'b0, 32'h0, 32'h0, 4'hF, 1, 32'h0, 1);
    run_round(1, 32'h0, 1, 1'b0, 32'h11C, 32'h0, 4'hF, TO + 1, 32'h0, 1);

    for (int r = 0; r < 150; r++) begin
      int          mode, il, fl;
      logic [31:0] ia, da;
      mode = $urandom_range(0, 4);
      ia   = 32'h100 + 32'(4 * $urandom_range(0, 15));
      da   = 32'h100 + 32'(4 * $urandom_range(0, 15));
      il   = (mode == 4) ? $urandom_range(1, TO) : rand_lat();
      fl   = rand_lat();
      run_round(mode, ia, il, 1'($urandom_range(0, 1)), da, $urandom,
                4'($urandom_range(1, 15)), rand_lat(), ia + 32'h200, fl);
    end

    // reset landing on the ack cycle of a data read
    @(posedge clk); #1;
    abort_ok = 1'b1;
    bus_q.push_back('{addr: 32'h208, we: 1'b0, wdata: 32'h0, be: 4'hF, lat: 2});
    data_we_i   = 1'b0;
    data_addr_i = 32'h208;
    data_be_i   = 4'hF;
    data_req_i  = 1'b1;
    cyc = 0;
    while (!mem_req_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_test_req_seen", 32'(mem_req_o), 32'd1);
    @(posedge clk); #1;
    rst        = 1'b1;
    data_req_i = 1'b0;
    @(posedge clk); #1;
    chk_reset("mid_reset");
    @(posedge clk); #1;
    rst      = 1'b0;
    last_rd  = 32'h0;
    exp_q.delete();
    @(posedge clk); #1;
    abort_ok = 1'b0;
    run_round(1, 32'h0, 1, 1'b1, 32'h104, 32'h1234_5678, 4'b1100, 1, 32'h0, 1);
    run_round(0, 32'h104, 2, 1'b0, 32'h0, 32'h0, 4'hF, 1, 32'h0, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
